uart_tx_cfg: RTL
================

# uart_tx_cfg

Parametrised UART transmitter with an input FIFO, successor to the fixed 8N1 transmitter in `top_uart`. It serialises words of configurable width with optional parity and 1 or 2 stop bits at a fixed clocks-per-bit rate. Words are accepted through a valid/ready handshake into a small FIFO so software-side producers can queue bursts. Frames are sent back-to-back with no idle gap while data is queued. It sits between the system logic and the board TXD pin.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 10416: clk cycles per serial bit (100 MHz / 9600 baud). Legal range is 2 or more.
- `DATA_BITS`, default 8: data bits per frame. Legal range is 5..9.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: legal values are 1 or 2.
- `FIFO_DEPTH`, default 4: number of queued words. Must be a power of 2, 2 or more.
- Illegal parameter values are a compile-time error.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `i_valid` in 1: a data word is offered.
- `i_data` in DATA_BITS: the word offered.
- `o_ready` in/out out 1: FIFO can accept a word; equals (count < FIFO_DEPTH).
- `o_txd` out 1: serial line, idle high. Registered.
- `o_busy` out 1: a frame is in progress (state ≠ IDLE). Registered.
- `o_fifo_count` out $clog2(FIFO_DEPTH+1): number of queued words, not counting the word in the shifter.

## Operation

- **Push:** a word is written at a clk edge where `i_valid && o_ready`. `o_ready` is derived from the current count only; a same-cycle pop does not open a slot.
- **Simultaneous push and pop:** the count is unchanged. Data order is strict FIFO.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
- **IDLE:** `o_txd` = 1. If count > 0, pop into the shifter, clear the bit counter, and go to START.
- **START:** `o_txd` = 0 for CLKS_PER_BIT cycles, then go to DATA.
- **DATA:** shift out DATA_BITS bits, LSB first, each for CLKS_PER_BIT cycles. Then go to PARITY if PARITY ≠ 0, otherwise go to STOP.
- **PARITY:** the bit makes the total number of ones in data+parity odd (PARITY=1) or even (PARITY=2). It is computed from the popped word at pop time.
- **STOP:** `o_txd` = 1 for STOP_BITS×CLKS_PER_BIT cycles.
  - At the last cycle, if count > 0, pop the next word and go directly to START, with no idle cycle.
  - Otherwise go to IDLE.
- **Baud counter:** counts 0..CLKS_PER_BIT-1 and wraps. The bit/state advances on wrap. The counter is cleared on every pop.
- **Frame length:** F = (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles.
- **Reset (asynchronous, any time including mid-frame):**
  - `o_txd` = 1, `o_busy` = 0, state = IDLE.
  - FIFO is flushed, so `o_fifo_count` = 0 and `o_ready` = 1.
  - Counters are cleared. A partially sent frame is abandoned; there is no resume.
- `i_data` is don't-care when `i_valid` = 0. Pushes while `o_ready` = 0 are dropped without side effects.

## Timing

- Word pushed into an empty FIFO while IDLE at edge k:
  - `o_fifo_count` = 1 after edge k.
  - Pop at edge k+1: `o_txd` = 0 and `o_busy` = 1 from edge k+1, and `o_fifo_count` = 0.
  - Latency from accept to start bit is 1 cycle.
- Each bit occupies exactly CLKS_PER_BIT cycles. `o_busy` stays high for exactly F cycles per isolated frame.
- For N queued frames, `o_busy` stays high for N×F cycles continuously.
- After the final stop bit, `o_txd` stays 1 and `o_busy` = 0 from the next edge.

## Test plan

Bench defaults: CLKS_PER_BIT=4, FIFO_DEPTH=4.

1. **8N1, 0xA3 pushed once.** `o_txd` sequence per 4-cycle bit is 0,1,1,0,0,0,1,0,1,1. `o_busy` is high for 40 cycles. Start bit begins 1 cycle after accept.
2. **Parity and stop bits, 0xA3.**
   - PARITY=2: parity bit 0, frame 44 cycles.
   - PARITY=1: parity bit 1.
   - PARITY=1, STOP_BITS=2: frame 48 cycles, with the stop level high for 8 cycles.
3. **DATA_BITS=5, PARITY=2, word 5'b10110.** Bits are 0,1,1,0,1, then parity 1, then stop. Frame is 32 cycles.
4. **FIFO full, 8N1.** Hold `i_valid` with distinct words d0..d5 on 6 consecutive cycles from IDLE.
   - d0..d4 are accepted and d5 is refused.
   - `o_ready` is 0 at d5's edge; `o_fifo_count` peaks at 4.
   - Five frames d0..d4 go out in order in exactly 200 cycles, with no idle cycle between frames.
5. **Reset mid-frame.** Assert `reset` during DATA of the first of 3 queued words, asynchronously between edges.
   - `o_txd` = 1, `o_busy` = 0 and `o_fifo_count` = 0 immediately.
   - After release, no further frames are sent until a new push.
   - A new push of 0x55 then yields a correct 40-cycle frame.
6. **Simultaneous push and pop.** Push exactly at the stop-bit last cycle with count=1. The count stays 1, and the next frame starts on the following cycle with the older word.

Source files
------------

// File: rtl/uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_cfg
// Description : Parametrised UART transmitter with an input FIFO. Serialises
//               DATA_BITS-wide words, LSB first, with optional odd/even
//               parity and 1 or 2 stop bits, CLKS_PER_BIT clocks per bit.
//               Queued words are sent back-to-back with no idle gap.
// Ports       : clk          - system clock
//               reset        - asynchronous active-high reset
//               i_valid      - a data word is offered
//               i_data       - offered word (DATA_BITS wide)
//               o_ready      - FIFO has a free slot (count < FIFO_DEPTH)
//               o_txd        - serial line, idle high (registered)
//               o_busy       - frame in progress (registered)
//               o_fifo_count - queued words, excluding the word in the shifter
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_cfg #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               i_valid,
  input  logic [DATA_BITS-1:0]               i_data,
  output logic                               o_ready,
  output logic                               o_txd,
  output logic                               o_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_fifo_count
);

  // --------------------------------------------------------------------------
  // Parameter legality
  // --------------------------------------------------------------------------
  generate
    if (CLKS_PER_BIT < 2) begin : g_chk_cpb
      $error("uart_tx_cfg: CLKS_PER_BIT must be 2 or more");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_dbits
      $error("uart_tx_cfg: DATA_BITS must be in 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_chk_parity
      $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
      $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
      $error("uart_tx_cfg: FIFO_DEPTH must be a power of 2, 2 or more");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_CW  = $clog2(FIFO_DEPTH + 1);
  localparam int c_AW  = $clog2(FIFO_DEPTH);
  localparam int c_BCW = $clog2(CLKS_PER_BIT);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_START  = 3'd1;
  localparam logic [2:0] c_DATA   = 3'd2;
  localparam logic [2:0] c_PARITY = 3'd3;
  localparam logic [2:0] c_STOP   = 3'd4;

  localparam logic [c_BCW-1:0] c_BAUD_LAST = c_BCW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       c_DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       c_STOP_LAST = 4'(STOP_BITS - 1);

  // --------------------------------------------------------------------------
  // Signals
  // --------------------------------------------------------------------------
  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [c_AW-1:0]      r_wr_ptr;
  logic [c_AW-1:0]      r_rd_ptr;
  logic [c_CW-1:0]      r_count;

  logic [2:0]           r_state;
  logic [2:0]           w_state_nxt;
  logic [c_BCW-1:0]     r_baud;
  logic [3:0]           r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic                 r_par;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_wrap;
  logic                 w_fifo_nempty;
  logic [DATA_BITS-1:0] w_head;
  logic                 w_head_xor;
  logic                 w_txd_nxt;
  logic                 w_busy_nxt;

  // --------------------------------------------------------------------------
  // FIFO
  // --------------------------------------------------------------------------
  // Ready depends only on the current count, so a same-cycle pop never
  // frees a slot for the push in that cycle.
  assign o_ready       = (r_count < c_CW'(FIFO_DEPTH));
  assign w_push        = i_valid && o_ready;
  assign w_fifo_nempty = (r_count != '0);
  assign w_head        = r_mem[r_rd_ptr];
  assign w_head_xor    = ^w_head;
  assign o_fifo_count  = r_count;

  // Storage is not reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and pop decision
  // --------------------------------------------------------------------------
  assign w_wrap = (r_baud == c_BAUD_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      c_IDLE: begin
        if (w_fifo_nempty) begin
          w_pop       = 1'b1;
          w_state_nxt = c_START;
        end
      end
      c_START: begin
        if (w_wrap) begin
          w_state_nxt = c_DATA;
        end
      end
      c_DATA: begin
        if (w_wrap && (r_bit == c_DATA_LAST)) begin
          w_state_nxt = (PARITY != 0) ? c_PARITY : c_STOP;
        end
      end
      c_PARITY: begin
        if (w_wrap) begin
          w_state_nxt = c_STOP;
        end
      end
      c_STOP: begin
        // Last stop cycle: chain straight into the next frame if one waits.
        if (w_wrap && (r_bit == c_STOP_LAST)) begin
          if (w_fifo_nempty) begin
            w_pop       = 1'b1;
            w_state_nxt = c_START;
          end else begin
            w_state_nxt = c_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = c_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs (computed from the next state so the pins are registered
  // and change on the same edge as the state)
  // --------------------------------------------------------------------------
  always_comb begin
    w_shift_nxt = r_shift;
    if (w_pop) begin
      w_shift_nxt = w_head;
    end else if ((r_state == c_DATA) && w_wrap) begin
      w_shift_nxt = r_shift >> 1;
    end
  end

  always_comb begin
    w_txd_nxt  = 1'b1;
    w_busy_nxt = (w_state_nxt != c_IDLE);
    case (w_state_nxt)
      c_IDLE:   w_txd_nxt = 1'b1;
      c_START:  w_txd_nxt = 1'b0;
      c_DATA:   w_txd_nxt = w_shift_nxt[0];
      c_PARITY: w_txd_nxt = r_par;
      c_STOP:   w_txd_nxt = 1'b1;
      default:  w_txd_nxt = 1'b1;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      o_txd   <= 1'b1;
      o_busy  <= 1'b0;
    end else begin
      if (w_pop || (r_state == c_IDLE) || w_wrap) begin
        r_baud <= '0;
      end else begin
        r_baud <= r_baud + c_BCW'(1);
      end

      // Any state change restarts the bit index for the new state.
      if (w_state_nxt != r_state) begin
        r_bit <= '0;
      end else if (w_wrap && ((r_state == c_DATA) || (r_state == c_STOP))) begin
        r_bit <= r_bit + 4'd1;
      end

      r_shift <= w_shift_nxt;

      // Parity is latched with the word so the shifter can be consumed freely.
      if (w_pop) begin
        r_par <= (PARITY == 1) ? ~w_head_xor : w_head_xor;
      end

      o_txd  <= w_txd_nxt;
      o_busy <= w_busy_nxt;
    end
  end

endmodule
`default_nettype wire
